// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main control sequencer for the multicycle RV32I core. Each instruction is
// stepped through fetch, decode, execute, memory and writeback states. The
// block drives the datapath mux selects and the ALU operation class. Memory
// accesses stall on a single-bit ready handshake. Unsupported opcodes park
// the sequencer in TRAP until the next reset.
//
// Ports
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset
//   op          instruction[6:0] from the instruction register
//   zero        ALU zero flag (qualifies pc_write in BEQ)
//   mem_ready   memory completes the current read/write this cycle
//   pc_write    PC load enable
//   adr_src     memory address select: 0 = PC, 1 = ALUOut
//   mem_read    memory read request
//   mem_write   memory write request
//   ir_write    instruction register / OldPC load enable
//   reg_write   register file write enable
//   result_src  00 = ALUOut, 01 = Data, 10 = ALUResult
//   alu_src_a   00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
//   alu_src_b   00 = rs2, 01 = ImmExt, 10 = constant 4
//   alu_op      00 = add, 01 = subtract, 10 = funct-decoded
//   state       current state encoding (debug)
//   illegal     high while in TRAP
//   instret     retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_control_fsm (
    input  logic        clk,
    input  logic        resetn,
    input  logic [6:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_UNUSED   = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Control word that depends on the state alone; the mem_ready / zero
    // qualified strobes are combined in after the register.
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
            S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            S_MEMREAD:  begin c.mem_read = 1'b1; c.adr_src = 1'b1; end
            S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            S_MEMWRITE: begin c.mem_write = 1'b1; c.adr_src = 1'b1; end
            S_EXECUTER: begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
            S_ALUWB:    begin c.reg_write = 1'b1; end
            S_EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
            S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
            S_BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; end
            S_JALR:     begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            S_JALR2:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
            S_LUI:      begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b01; end
            S_TRAP:     begin c.illegal = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    state_t      r_state;
    ctrl_t       r_ctrl;
    logic        r_run;      // low during reset and the first cycle after release
    logic [31:0] r_instret;
    state_t      w_next;
    logic        w_retire;
    logic        w_fetch_go;

    // NOTE: every variable driven here gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        if (!r_run) begin
            // Outputs were forced low during reset; spend one cycle bringing
            // FETCH requests up before the handshake is allowed to advance.
            w_next = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) w_next = S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: w_next = S_MEMADR;
                        OP_RTYPE:          w_next = S_EXECUTER;
                        OP_ITYPE:          w_next = S_EXECUTEI;
                        OP_JAL:            w_next = S_JAL;
                        OP_JALR:           w_next = S_JALR;
                        OP_BRANCH:         w_next = S_BEQ;
                        OP_LUI:            w_next = S_LUI;
                        default:           w_next = S_TRAP;
                    endcase
                end
                S_MEMADR:   w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
                S_MEMWB:    begin w_next = S_FETCH; w_retire = 1'b1; end
                S_MEMWRITE: if (mem_ready) begin w_next = S_FETCH; w_retire = 1'b1; end
                S_EXECUTER: w_next = S_ALUWB;
                S_ALUWB:    begin w_next = S_FETCH; w_retire = 1'b1; end
                S_EXECUTEI: w_next = S_ALUWB;
                S_JAL:      w_next = S_ALUWB;
                S_BEQ:      begin w_next = S_FETCH; w_retire = 1'b1; end
                S_JALR:     w_next = S_JALR2;
                S_JALR2:    w_next = S_ALUWB;
                S_LUI:      w_next = S_ALUWB;
                S_TRAP:     w_next = S_TRAP;
                default:    w_next = S_TRAP;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_FETCH;
            r_ctrl    <= '0;
            r_run     <= 1'b0;
            r_instret <= '0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next;
            // Decode for the state being entered, so the outputs are
            // registered yet line up with the state they belong to.
            r_ctrl  <= decode_ctrl(w_next);
            if (w_retire) r_instret <= r_instret + 32'd1;
        end
    end

    // Handshake-qualified strobes; r_run keeps them low through reset exit.
    assign w_fetch_go = r_run && (r_state == S_FETCH) && mem_ready;

    assign pc_write   = r_ctrl.pc_write | w_fetch_go | ((r_state == S_BEQ) && zero);
    assign ir_write   = r_ctrl.ir_write | w_fetch_go;
    assign adr_src    = r_ctrl.adr_src;
    assign mem_read   = r_ctrl.mem_read;
    assign mem_write  = r_ctrl.mem_write;
    assign reg_write  = r_ctrl.reg_write;
    assign result_src = r_ctrl.result_src;
    assign alu_src_a  = r_ctrl.alu_src_a;
    assign alu_src_b  = r_ctrl.alu_src_b;
    assign alu_op     = r_ctrl.alu_op;
    assign illegal    = r_ctrl.illegal;
    assign state      = r_state;
    assign instret    = r_instret;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control sequencer for the multicycle RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the mux selects and ALU operation class consumed by the ALU decoder and datapath. It inserts memory wait states through a single-bit ready handshake and halts in a trap state on unsupported opcodes.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- op  in  7  instruction[6:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read or write this cycle
- pc_write  out  1  PC load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register / OldPC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 (A), 11 = zero
- alu_src_b  out  2  00 = rs2 (B), 01 = ImmExt, 10 = constant 4
- alu_op  out  2  00 = add, 01 = subtract, 10 = funct-decoded
- state  out  4  current state, for debug
- illegal  out  1  high while in TRAP
- instret  out  32  retired-instruction counter

## Operation
Any output not listed for a state is 0 in that state.

State encoding and behaviour (next state in brackets):
- FETCH (0): mem_read=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write and pc_write equal mem_ready. [DECODE if mem_ready, else FETCH]
- DECODE (1): a=01, b=01, alu_op=00; ALUOut receives the branch/jal target. Next state by op:
  - 0000011 or 0100011: MEMADR
  - 0110011: EXECUTER
  - 0010011: EXECUTEI
  - 1101111: JAL
  - 1100111: JALR
  - 1100011: BEQ
  - 0110111: LUI
  - any other op: TRAP
- MEMADR (2): a=10, b=01, alu_op=00. [MEMREAD if op=0000011, else MEMWRITE]
- MEMREAD (3): mem_read=1, adr_src=1. [MEMWB on mem_ready, else hold]
- MEMWB (4): result_src=01, reg_write=1. [FETCH]
- MEMWRITE (5): mem_write=1, adr_src=1; requests held stable until mem_ready. [FETCH on mem_ready]
- EXECUTER (6): a=10, b=00, alu_op=10. [ALUWB]
- ALUWB (7): result_src=00, reg_write=1. [FETCH]
- EXECUTEI (8): a=10, b=01, alu_op=10. [ALUWB]
- JAL (9): a=01, b=10, alu_op=00, result_src=00, pc_write=1. [ALUWB]
- BEQ (10): a=10, b=00, alu_op=01, result_src=00, pc_write=zero (combinational). [FETCH]
- JALR (11): a=10, b=01, alu_op=00. [JALR2]
- JALR2 (12): a=01, b=10, alu_op=00, result_src=00, pc_write=1. [ALUWB]
- LUI (13): a=11, b=01, alu_op=00. [ALUWB]
- TRAP (15): illegal=1, all enables 0. [TRAP until reset]
- Encoding 14 is unused; if reached, next state is TRAP.

instret:
- Increments by 1, wrapping mod 2^32, on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.

## Timing
- Reset: while resetn=0, state=FETCH, instret=0, and every control output is forced to 0. On the first clk edge after release, FETCH outputs apply.
- State register and instret update on the rising clk edge. All outputs are decoded from the state, except pc_write/ir_write in FETCH (gated by mem_ready) and pc_write in BEQ (gated by zero).
- Cycle counts with mem_ready=1 in the same cycle as each request:
  - R-type, I-type, LUI: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles
  - jalr: 5 cycles
- Each cycle mem_ready stays low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs are held constant during the wait.
- mem_ready is ignored in every other state.
- resetn asserted mid-instruction aborts it immediately and asynchronously; no write enable glitches high.

## Test plan
- Reset and R-type: hold resetn=0 and check all outputs 0 and instret=0. Release, op=0110011, mem_ready=1 → states 0,1,6,7,0; reg_write=1 only in state 7; instret=1.
- lw with wait: op=0000011, mem_ready low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0; result_src=01 in MEMWB; 7 cycles total.
- sw: op=0100011, mem_ready=1 → mem_write=1 and adr_src=1 for exactly 1 cycle; reg_write never asserted; instret increments.
- beq taken and not taken: zero=1 → pc_write=1 in state 10; zero=0 → pc_write=0; 3 cycles each.
- jal and jalr: pc_write=1 in state 9 (resp. 12), then reg_write in state 7; jalr visits states 11 and 12.
- Illegal opcode and recovery: op=0000000 → TRAP with illegal=1 held for 10 cycles and instret frozen. Pulse resetn low mid-MEMREAD → state 0 and all outputs 0 immediately.
